flappy_engine: RTL
==================

// Module: flappy_engine
// PURPOSE
// Parametrised game-physics core for the flappy bird game: tick divider, bird height with jump/fall,
// NUM_COLS-column scrolling pipe field with LFSR-placed gaps, collision detection and BCD score.
// Sits between the game control FSM/keys and the VGA render block; render block reads bird_h, col_*.
// Generalises the fixed 2-bit obstacle shift register to parametrised height, columns, gap and spacing.
// PARAMETERS
// TICK_DIV     2500000  clk cycles per game tick (20 Hz at 50 MHz); >=2
// H_BITS       7        width of heights/gap positions
// PLAY_H       80       playfield height; legal bird_h 1..PLAY_H-2
// START_H      40       bird_h on entering IDLE
// NUM_COLS     8        on-screen pipe columns; column 0 = bird column
// GAP          20       vertical pipe-gap size in rows
// PIPE_SPACING 4        ticks between inserted pipes; >=1
// JUMP_TICKS   15       ticks of rise after a sampled jump
// LFSR_SEED    16'hACE1 LFSR reset value; nonzero
// PORTS
// clk       in   1                   system clock
// reset     in   1                   synchronous, active-high
// start     in   1                   IDLE->RUN, DEAD->IDLE (level, sampled per clk)
// jump      in   1                   jump request, level, sampled on tick only
// state     out  2                   0=IDLE 1=RUN 2=DEAD
// tick      out  1                   1-cycle pulse each game tick in RUN
// bird_h    out  H_BITS              bird height, 0 = floor
// going_up  out  1                   bird rising
// col_valid out  NUM_COLS            1 = column i holds a pipe
// col_gap   out  NUM_COLS*H_BITS     gap bottom row of column i at [i*H_BITS +: H_BITS]
// score     out  16                  4-digit BCD, [3:0] = units
// lose      out  1                   1-cycle pulse on collision
// BEHAVIOUR
// - Reset (dominates everything): state=IDLE, bird_h=START_H, going_up=0, rise_cnt=0, col_valid=0,
//   col_gap=0, score=0, tick=0, lose=0, div_cnt=TICK_DIV-1, sp_cnt=PIPE_SPACING-1, lfsr=LFSR_SEED.
// - LFSR: 16-bit Galois, poly x^16+x^14+x^13+x^11+1, advances every clk in every state.
// - IDLE: outputs held at reset values except lfsr; start=1 -> RUN next cycle.
// - RUN: div_cnt decrements each clk; at 0 reload TICK_DIV-1 and perform tick (tick=1 that cycle).
//   start ignored in RUN. Tick actions, all registered together (visible next cycle):
//   1 passed = col_valid[0] (pre-shift).
//   2 shift: col i <= col i+1; col NUM_COLS-1 <= new column. sp_cnt==0: new valid pipe,
//     gap = 1 + ((lfsr[7:0] * (PLAY_H-GAP-1)) >> 8), sp_cnt<=PIPE_SPACING-1; else invalid, gap 0, sp_cnt--.
//   3 bird: jump -> rise_cnt<=JUMP_TICKS-1, going_up=1; elif rise_cnt>0 -> rise_cnt--;
//     else going_up=0. new_h = going_up ? bird_h+1 : bird_h-1 (uses updated going_up).
//   4 collision on new values: new_h==0 | new_h>=PLAY_H-1 | (new col0 valid &
//     (new_h<gap0 | new_h>gap0+GAP-1)). Collision -> lose pulse, state<=DEAD, score unchanged.
//   5 no collision & passed -> score BCD +1 with digit carry; saturates at 9999.
// - DEAD: all outputs frozen (tick=0, lose=0 after pulse); start=1 -> IDLE (re-init as reset, except lfsr).
// - Widths: internal height math in H_BITS+1 bits, no wrap; gap+GAP-1 never exceeds PLAY_H-2.
// TESTING (TICK_DIV=4, defaults otherwise)
// - Reset, idle 20 cycles -> state=0, bird_h=40, col_valid=0, score=16'h0000, tick never pulses.
// - start, no jump, PIPE_SPACING=64 -> bird_h 39,38.. each tick; 40th tick lose pulse, bird_h=0, state=2.
// - jump high for one tick at bird_h=40 -> bird_h rises to 55 over 15 ticks, then going_up=0, falls.
// - jump held high -> bird_h climbs to 79, lose pulse that tick, state=2; further ticks stop.
// - Seed known, bird steered inside gaps (model-driven jump) -> score 0001 tick after first pipe leaves col 0;
//   preload score 0009 -> 0010; 9999 stays 9999.
// - reset high mid-RUN -> next cycle all reset values; DEAD + start -> IDLE, second start -> RUN.

Source files
------------

// File: rtl/flappy_engine.sv
// Game-physics core: tick divider, bird height, scrolling pipe columns with
// LFSR-placed gaps, collision detection and a saturating 4-digit BCD score.
module flappy_engine #(
  parameter int          TICK_DIV     = 2500000,
  parameter int          H_BITS       = 7,
  parameter int          PLAY_H       = 80,
  parameter int          START_H      = 40,
  parameter int          NUM_COLS     = 8,
  parameter int          GAP          = 20,
  parameter int          PIPE_SPACING = 4,
  parameter int          JUMP_TICKS   = 15,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_start,
  input  logic                       i_jump,
  output logic [1:0]                 o_state,
  output logic                       o_tick,
  output logic [H_BITS-1:0]          o_bird_h,
  output logic                       o_going_up,
  output logic [NUM_COLS-1:0]        o_col_valid,
  output logic [NUM_COLS*H_BITS-1:0] o_col_gap,
  output logic [15:0]                o_score,
  output logic                       o_lose
);

  localparam int DIV_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SP_W      = (PIPE_SPACING > 1) ? $clog2(PIPE_SPACING) : 1;
  localparam int RISE_W    = (JUMP_TICKS > 1) ? $clog2(JUMP_TICKS) : 1;
  localparam int HW        = H_BITS + 1;
  localparam int GAP_RANGE = PLAY_H - GAP - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DEAD = 2'd2
  } state_t;

  state_t                      r_state, w_state_next;
  logic [DIV_W-1:0]            r_div_cnt;
  logic [SP_W-1:0]             r_sp_cnt;
  logic [15:0]                 r_lfsr;
  logic [H_BITS-1:0]           r_bird_h;
  logic                        r_going_up;
  logic [RISE_W-1:0]           r_rise_cnt;
  logic [NUM_COLS-1:0]         r_col_valid;
  logic [NUM_COLS*H_BITS-1:0]  r_col_gap;
  logic [15:0]                 r_score;
  logic                        r_lose;

  logic                        w_tick;
  logic                        w_init;
  logic [NUM_COLS-1:0]         w_valid_sh;
  logic [NUM_COLS*H_BITS-1:0]  w_gap_sh;
  logic [H_BITS+7:0]           w_prod;
  logic [H_BITS-1:0]           w_new_gap;
  logic [H_BITS-1:0]           w_gap0;
  logic                        w_up_next;
  logic [RISE_W-1:0]           w_rise_next;
  logic [HW-1:0]               w_new_h;
  logic                        w_collide;
  logic [15:0]                 w_score_inc;

  assign w_tick = (r_state == S_RUN) && (r_div_cnt == '0);
  assign w_init = i_reset || ((r_state == S_DEAD) && i_start);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_next = S_RUN;
      S_RUN:   if (w_tick && w_collide) w_state_next = S_DEAD;
      S_DEAD:  if (i_start) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // Galois LFSR, taps x^16+x^14+x^13+x^11+1; free-runs so gaps depend on player timing
  always_ff @(posedge i_clk) begin
    if (i_reset) r_lfsr <= LFSR_SEED;
    else         r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  // Column shift toward the bird; new column enters at the far edge
  for (genvar gi = 0; gi < NUM_COLS - 1; gi++) begin : g_shift
    assign w_valid_sh[gi]                 = r_col_valid[gi+1];
    assign w_gap_sh[gi*H_BITS +: H_BITS]  = r_col_gap[(gi+1)*H_BITS +: H_BITS];
  end

  assign w_prod    = {{H_BITS{1'b0}}, r_lfsr[7:0]} * (H_BITS+8)'(GAP_RANGE);
  assign w_new_gap = H_BITS'(w_prod >> 8) + H_BITS'(1);
  assign w_valid_sh[NUM_COLS-1] = (r_sp_cnt == '0);
  assign w_gap_sh[(NUM_COLS-1)*H_BITS +: H_BITS] = (r_sp_cnt == '0) ? w_new_gap : '0;
  assign w_gap0 = w_gap_sh[H_BITS-1:0];

  always_comb begin
    w_rise_next = r_rise_cnt;
    w_up_next   = r_going_up;
    if (i_jump) begin
      w_rise_next = RISE_W'(JUMP_TICKS - 1);
      w_up_next   = 1'b1;
    end else if (r_rise_cnt != '0) begin
      w_rise_next = r_rise_cnt - RISE_W'(1);
    end else begin
      w_up_next = 1'b0;
    end
  end

  // Bird never sits at 0 while running, so the decrement cannot wrap
  assign w_new_h = w_up_next ? ({1'b0, r_bird_h} + HW'(1)) : ({1'b0, r_bird_h} - HW'(1));

  assign w_collide = (w_new_h == '0) || (w_new_h >= HW'(PLAY_H - 1)) ||
                     (w_valid_sh[0] && ((w_new_h < {1'b0, w_gap0}) ||
                                        (w_new_h > ({1'b0, w_gap0} + HW'(GAP - 1)))));

  always_comb begin : bcd_inc
    logic carry;
    w_score_inc = r_score;
    carry       = 1'b1;
    if (r_score != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r_score[4*i +: 4] == 4'd9) begin
            w_score_inc[4*i +: 4] = 4'd0;
          end else begin
            w_score_inc[4*i +: 4] = r_score[4*i +: 4] + 4'd1;
            carry                 = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    r_lose <= 1'b0;
    if (w_init) begin
      r_div_cnt   <= DIV_W'(TICK_DIV - 1);
      r_sp_cnt    <= SP_W'(PIPE_SPACING - 1);
      r_bird_h    <= H_BITS'(START_H);
      r_going_up  <= 1'b0;
      r_rise_cnt  <= '0;
      r_col_valid <= '0;
      r_col_gap   <= '0;
      r_score     <= '0;
    end else if (r_state == S_RUN) begin
      if (w_tick) begin
        r_div_cnt   <= DIV_W'(TICK_DIV - 1);
        r_col_valid <= w_valid_sh;
        r_col_gap   <= w_gap_sh;
        if (r_sp_cnt == '0) r_sp_cnt <= SP_W'(PIPE_SPACING - 1);
        else                r_sp_cnt <= r_sp_cnt - SP_W'(1);
        r_bird_h    <= w_new_h[H_BITS-1:0];
        r_going_up  <= w_up_next;
        r_rise_cnt  <= w_rise_next;
        if (w_collide)           r_lose  <= 1'b1;
        else if (r_col_valid[0]) r_score <= w_score_inc;
      end else begin
        r_div_cnt <= r_div_cnt - DIV_W'(1);
      end
    end
  end

  assign o_state     = r_state;
  assign o_tick      = w_tick;
  assign o_bird_h    = r_bird_h;
  assign o_going_up  = r_going_up;
  assign o_col_valid = r_col_valid;
  assign o_col_gap   = r_col_gap;
  assign o_score     = r_score;
  assign o_lose      = r_lose;

endmodule
